vsif_packet_builder: RTL and testbench

//  Runtime-configurable Vendor-Specific InfoFrame (type 0x81) source for the HDMI packet picker.

---
 rtl/vsif_packet_builder_if.sv | 34 +++
 rtl/vsif_packet_builder.sv | 239 +++++++++++++++++++++++
 tb/tb_vsif_packet_builder.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/vsif_packet_builder_if.sv
// Bundle of configuration, raw-payload, control and packet outputs for the
// Vendor-Specific InfoFrame builder.
interface vsif_packet_builder_if;
    logic [1:0]        cfg_mode;
    logic              cfg_allm;
    logic              cfg_ll;
    logic              cfg_game;
    logic [7:0]        raw_version;
    logic [4:0]        raw_length;
    logic              raw_wr_en;
    logic [4:0]        raw_wr_addr;
    logic [7:0]        raw_wr_data;
    logic              update;
    logic              frame_start;
    logic              busy;
    logic              committed;
    logic              packet_valid;
    logic [23:0]       header;
    logic [3:0][55:0]  sub;

    modport master (
        output cfg_mode, cfg_allm, cfg_ll, cfg_game,
        output raw_version, raw_length, raw_wr_en, raw_wr_addr, raw_wr_data,
        output update, frame_start,
        input  busy, committed, packet_valid, header, sub
    );

    modport slave (
        input  cfg_mode, cfg_allm, cfg_ll, cfg_game,
        input  raw_version, raw_length, raw_wr_en, raw_wr_addr, raw_wr_data,
        input  update, frame_start,
        output busy, committed, packet_valid, header, sub
    );
endinterface

// File: rtl/vsif_packet_builder.sv
// Vendor-Specific InfoFrame (type 0x81) source: serial byte assembly, PB0
// checksum, staging buffer committed to the active outputs on frame_start.
module vsif_packet_builder #(
    parameter int MAX_LENGTH = 27,
    parameter bit AUTO_BUILD = 1'b1,
    parameter bit RAW_ENABLE = 1'b1
) (
    input  logic                 clk_pixel,
    input  logic                 reset_n,
    vsif_packet_builder_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUILD = 2'd1,
        ST_CSUM  = 2'd2,
        ST_READY = 2'd3
    } state_t;

    localparam logic [4:0] MAX_LEN5 = 5'(MAX_LENGTH);
    localparam logic [4:0] LAST_K   = 5'd27;

    state_t            state_r;
    state_t            state_next_s;
    logic              upd_s;
    logic              commit_s;
    logic              auto_pend_r;
    logic [1:0]        mode_in_s;
    logic [4:0]        len_in_s;
    logic [23:0]       hdr_in_s;
    logic [7:0]        raw_sel_s;
    logic [7:0]        byte_s;
    logic              raw_wr_ok_s;

    logic [1:0]        mode_r;
    logic              allm_r;
    logic              ll_r;
    logic              game_r;
    logic [4:0]        len_r;
    logic [4:0]        k_r;
    logic [7:0]        acc_r;
    logic [23:0]       stg_hdr_r;
    logic [27:0][7:0]  stg_pb_r;
    logic [27:1][7:0]  raw_buf_r;
    logic [23:0]       header_r;
    logic [3:0][55:0]  sub_r;
    logic              valid_r;
    logic              committed_r;
    logic              busy_r;

    function automatic logic [23:0] hdr_bytes(input logic [1:0] mode,
                                              input logic [7:0] version,
                                              input logic [4:0] len);
        logic [23:0] h;
        case (mode)
            2'd1:    h = {8'h1B, 8'h01, 8'h81};
            2'd2:    h = {3'b000, len, version, 8'h81};
            default: h = {8'h05, 8'h01, 8'h81};
        endcase
        return h;
    endfunction

    function automatic logic [7:0] hdr_sum(input logic [23:0] h);
        return h[7:0] + h[15:8] + h[23:16];
    endfunction

    function automatic logic [7:0] pb_byte(input logic [1:0] mode,
                                           input logic       allm,
                                           input logic       ll,
                                           input logic       game,
                                           input logic [4:0] k,
                                           input logic [4:0] len,
                                           input logic [7:0] raw);
        logic [7:0] b;
        b = 8'h00;
        case (mode)
            2'd1: begin
                case (k)
                    5'd1:    b = 8'h46;
                    5'd2:    b = 8'hD0;
                    5'd4:    b = {6'b000000, 1'b1, ll};
                    5'd5:    b = game ? 8'h20 : 8'h00;
                    default: b = 8'h00;
                endcase
            end
            2'd2: begin
                if (k <= len) b = raw;
                else          b = 8'h00;
            end
            default: begin
                case (k)
                    5'd1:    b = 8'hD8;
                    5'd2:    b = 8'h5D;
                    5'd3:    b = 8'hC4;
                    5'd4:    b = 8'h01;
                    5'd5:    b = {6'b000000, allm, 1'b0};
                    default: b = 8'h00;
                endcase
            end
        endcase
        if (k > MAX_LEN5) b = 8'h00;
        else              b = b;
        return b;
    endfunction

    assign upd_s = bus.update | auto_pend_r;

    // Live-input decode used only on the snapshot edge
    always_comb begin
        mode_in_s = 2'd0;
        case (bus.cfg_mode)
            2'd1:    mode_in_s = 2'd1;
            2'd2:    mode_in_s = RAW_ENABLE ? 2'd2 : 2'd0;
            default: mode_in_s = 2'd0;
        endcase
        if (bus.raw_length > MAX_LEN5) len_in_s = MAX_LEN5;
        else                           len_in_s = bus.raw_length;
        hdr_in_s = hdr_bytes(mode_in_s, bus.raw_version, len_in_s);
    end

    // Payload byte for the current build index
    always_comb begin
        raw_sel_s = 8'h00;
        if ((k_r != 5'd0) && (k_r <= LAST_K)) raw_sel_s = raw_buf_r[k_r];
        else                                  raw_sel_s = 8'h00;
        byte_s = pb_byte(mode_r, allm_r, ll_r, game_r, k_r, len_r, raw_sel_s);
    end

    // Next-state logic; a new update always restarts the build
    always_comb begin
        state_next_s = state_r;
        commit_s     = 1'b0;
        if (upd_s) begin
            state_next_s = ST_BUILD;
        end else begin
            case (state_r)
                ST_BUILD: begin
                    if (k_r == LAST_K) state_next_s = ST_CSUM;
                    else               state_next_s = ST_BUILD;
                end
                ST_CSUM:  state_next_s = ST_READY;
                ST_READY: begin
                    if (bus.frame_start) begin
                        state_next_s = ST_IDLE;
                        commit_s     = 1'b1;
                    end else begin
                        state_next_s = ST_READY;
                    end
                end
                ST_IDLE:  state_next_s = ST_IDLE;
                default:  state_next_s = ST_IDLE;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) state_r <= ST_IDLE;
        else          state_r <= state_next_s;
    end

    // Snapshot, serial staging build and checksum accumulation
    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            auto_pend_r <= AUTO_BUILD;
            mode_r      <= 2'd0;
            allm_r      <= 1'b0;
            ll_r        <= 1'b0;
            game_r      <= 1'b0;
            len_r       <= 5'd0;
            k_r         <= 5'd0;
            acc_r       <= 8'h00;
            stg_hdr_r   <= 24'h000000;
            stg_pb_r    <= '0;
        end else begin
            auto_pend_r <= 1'b0;
            if (upd_s) begin
                mode_r    <= mode_in_s;
                allm_r    <= bus.cfg_allm;
                ll_r      <= bus.cfg_ll;
                game_r    <= bus.cfg_game;
                len_r     <= len_in_s;
                k_r       <= 5'd1;
                acc_r     <= hdr_sum(hdr_in_s);
                stg_hdr_r <= hdr_in_s;
            end else if (state_r == ST_BUILD) begin
                stg_pb_r[k_r] <= byte_s;
                acc_r         <= acc_r + byte_s;
                k_r           <= k_r + 5'd1;
            end else if (state_r == ST_CSUM) begin
                stg_pb_r[0] <= 8'h00 - acc_r;
            end else begin
                k_r <= k_r;
            end
        end
    end

    assign raw_wr_ok_s = RAW_ENABLE && bus.raw_wr_en && !busy_r &&
                         (bus.raw_wr_addr >= 5'd1) && (bus.raw_wr_addr <= LAST_K);

    // Raw payload buffer; frozen while a build is in flight
    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            raw_buf_r <= '0;
        end else if (raw_wr_ok_s) begin
            raw_buf_r[bus.raw_wr_addr] <= bus.raw_wr_data;
        end else begin
            raw_buf_r <= raw_buf_r;
        end
    end

    // Active outputs change only at the commit edge
    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            header_r    <= 24'h000000;
            sub_r       <= '0;
            valid_r     <= 1'b0;
            committed_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            committed_r <= commit_s;
            busy_r      <= (state_next_s != ST_IDLE);
            if (commit_s) begin
                header_r <= stg_hdr_r;
                sub_r    <= stg_pb_r;
                valid_r  <= 1'b1;
            end else begin
                header_r <= header_r;
            end
        end
    end

    assign bus.header       = header_r;
    assign bus.sub          = sub_r;
    assign bus.packet_valid = valid_r;
    assign bus.committed    = committed_r;
    assign bus.busy         = busy_r;

endmodule

// File: tb/tb_vsif_packet_builder.sv
// Directed bench for vsif_packet_builder with hand-computed packet bytes.
module tb_vsif_packet_builder;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    vsif_packet_builder_if bus ();

    vsif_packet_builder #(
        .MAX_LENGTH (27),
        .AUTO_BUILD (1'b1),
        .RAW_ENABLE (1'b1)
    ) dut (
        .clk_pixel (clk),
        .reset_n   (rst_n),
        .bus       (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic raw_write(input logic [4:0] addr, input logic [7:0] data);
        bus.raw_wr_en   = 1'b1;
        bus.raw_wr_addr = addr;
        bus.raw_wr_data = data;
        step();
        bus.raw_wr_en   = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        bus.cfg_mode    = 2'd0;
        bus.cfg_allm    = 1'b1;
        bus.cfg_ll      = 1'b0;
        bus.cfg_game    = 1'b0;
        bus.raw_version = 8'h00;
        bus.raw_length  = 5'd0;
        bus.raw_wr_en   = 1'b0;
        bus.raw_wr_addr = 5'd0;
        bus.raw_wr_data = 8'h00;
        bus.update      = 1'b0;
        bus.frame_start = 1'b0;
        #12;
        check("reset_header", 64'(bus.header), 64'h0);
        check("reset_valid", 64'(bus.packet_valid), 64'h0);
        check("reset_busy", 64'(bus.busy), 64'h0);

        // Test 1: auto build after reset release, HF-VSIF with ALLM
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("t1_busy_after_auto", 64'(bus.busy), 64'h1);
        check("t1_valid_before", 64'(bus.packet_valid), 64'h0);
        repeat (38) step();
        bus.frame_start = 1'b1;
        step();
        bus.frame_start = 1'b0;
        check("t1_committed", 64'(bus.committed), 64'h1);
        check("t1_header", 64'(bus.header), 64'h050181);
        check("t1_sub0", 64'(bus.sub[0]), 64'h00_02_01_C4_5D_D8_7D);
        check("t1_sub1", 64'(bus.sub[1]), 64'h0);
        check("t1_sub2", 64'(bus.sub[2]), 64'h0);
        check("t1_sub3", 64'(bus.sub[3]), 64'h0);
        check("t1_valid", 64'(bus.packet_valid), 64'h1);
        check("t1_busy", 64'(bus.busy), 64'h0);
        step();
        check("t1_committed_pulse", 64'(bus.committed), 64'h0);

        // Test 2: Dolby VSIF; frame_start during CSUM ignored, next edge commits
        bus.cfg_mode = 2'd1;
        bus.cfg_ll   = 1'b1;
        bus.cfg_game = 1'b1;
        bus.update   = 1'b1;
        step();
        bus.update   = 1'b0;
        repeat (27) step();
        bus.frame_start = 1'b1;
        step();
        check("t2_no_commit_csum", 64'(bus.committed), 64'h0);
        check("t2_header_held", 64'(bus.header), 64'h050181);
        step();
        bus.frame_start = 1'b0;
        check("t2_committed", 64'(bus.committed), 64'h1);
        check("t2_header", 64'(bus.header), 64'h1B0181);
        check("t2_sub0", 64'(bus.sub[0]), 64'h00_20_03_00_D0_46_2A);

        // Test 3: frame_start at BUILD k=10 ignored
        bus.cfg_mode = 2'd0;
        bus.cfg_allm = 1'b0;
        bus.update   = 1'b1;
        step();
        bus.update   = 1'b0;
        repeat (9) step();
        bus.frame_start = 1'b1;
        step();
        bus.frame_start = 1'b0;
        check("t3_no_commit_build", 64'(bus.committed), 64'h0);
        check("t3_header_held", 64'(bus.header), 64'h1B0181);
        check("t3_busy", 64'(bus.busy), 64'h1);
        repeat (18) step();
        bus.frame_start = 1'b1;
        step();
        bus.frame_start = 1'b0;
        check("t3_committed", 64'(bus.committed), 64'h1);
        check("t3_header", 64'(bus.header), 64'h050181);
        check("t3_sub0", 64'(bus.sub[0]), 64'h00_00_01_C4_5D_D8_7F);

        // Test 4: update and frame_start together in READY -> update wins
        bus.cfg_mode = 2'd1;
        bus.cfg_ll   = 1'b0;
        bus.cfg_game = 1'b0;
        bus.update   = 1'b1;
        step();
        bus.update   = 1'b0;
        repeat (28) step();
        bus.update      = 1'b1;
        bus.frame_start = 1'b1;
        step();
        bus.update      = 1'b0;
        bus.frame_start = 1'b0;
        check("t4_no_commit", 64'(bus.committed), 64'h0);
        check("t4_busy", 64'(bus.busy), 64'h1);
        check("t4_header_held", 64'(bus.header), 64'h050181);
        repeat (28) step();
        bus.frame_start = 1'b1;
        step();
        bus.frame_start = 1'b0;
        check("t4_committed", 64'(bus.committed), 64'h1);
        check("t4_sub0", 64'(bus.sub[0]), 64'h00_00_02_00_D0_46_4B);

        // Test 5: raw mode; out-of-range and busy-time writes dropped
        raw_write(5'd1, 8'h11);
        raw_write(5'd2, 8'h22);
        raw_write(5'd3, 8'h33);
        raw_write(5'd28, 8'hFF);
        raw_write(5'd0, 8'hAA);
        bus.cfg_mode    = 2'd2;
        bus.raw_version = 8'h02;
        bus.raw_length  = 5'd3;
        bus.update      = 1'b1;
        step();
        bus.update      = 1'b0;
        raw_write(5'd3, 8'hEE);
        repeat (27) step();
        bus.frame_start = 1'b1;
        step();
        bus.frame_start = 1'b0;
        check("t5_committed", 64'(bus.committed), 64'h1);
        check("t5_header", 64'(bus.header), 64'h030281);
        check("t5_sub0", 64'(bus.sub[0]), 64'h00_00_00_33_22_11_14);
        check("t5_sub1", 64'(bus.sub[1]), 64'h0);

        // Raw length beyond the limit clamps to 27
        bus.raw_length = 5'd31;
        bus.update     = 1'b1;
        step();
        bus.update     = 1'b0;
        repeat (28) step();
        bus.frame_start = 1'b1;
        step();
        bus.frame_start = 1'b0;
        check("t5_clamp_header", 64'(bus.header), 64'h1B0281);
        check("t5_clamp_sub0", 64'(bus.sub[0]), 64'h00_00_00_33_22_11_FC);

        // Test 6: asynchronous reset mid-build, then auto rebuild
        bus.cfg_mode = 2'd0;
        bus.cfg_allm = 1'b1;
        bus.update   = 1'b1;
        step();
        bus.update   = 1'b0;
        repeat (5) step();
        #1;
        rst_n = 1'b0;
        #1;
        check("t6_rst_header", 64'(bus.header), 64'h0);
        check("t6_rst_sub0", 64'(bus.sub[0]), 64'h0);
        check("t6_rst_valid", 64'(bus.packet_valid), 64'h0);
        check("t6_rst_busy", 64'(bus.busy), 64'h0);
        check("t6_rst_committed", 64'(bus.committed), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("t6_auto_busy", 64'(bus.busy), 64'h1);
        repeat (28) step();
        bus.frame_start = 1'b1;
        step();
        bus.frame_start = 1'b0;
        check("t6_committed", 64'(bus.committed), 64'h1);
        check("t6_header", 64'(bus.header), 64'h050181);
        check("t6_sub0", 64'(bus.sub[0]), 64'h00_02_01_C4_5D_D8_7D);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
